rtc_refresh_scheduler: RTL and testbench

//  Sequences RTC register traffic for the VGA clock display. Periodically reads the 8 timekeeping

---
 rtl/rtc_refresh_scheduler.sv | 238 +++++++++++++++++++++++
 tb/tb_rtc_refresh_scheduler.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_refresh_scheduler.sv
// Periodically reads the RTC timekeeping registers over the shared bus engine, buffers them and
// streams them out with inicioSecuencia framing; user write requests are arbitrated onto the same bus.
module rtc_refresh_scheduler #(
  parameter int unsigned N_REGS      = 8,
  parameter logic [7:0]  BASE_ADDR   = 8'h21,
  parameter int unsigned REFRESH_DIV = 1,
  parameter int unsigned LEAD        = 10,
  parameter int unsigned TRAIL       = 3,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  output logic       bus_req,
  output logic       bus_we,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  input  logic       bus_done,
  input  logic [7:0] bus_rdata,
  output logic       inicioSecuencia,
  output logic [7:0] datoRTC,
  output logic       busy,
  output logic       err
);

  localparam int unsigned IDX_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int unsigned TOTAL = LEAD + N_REGS + TRAIL;
  localparam int unsigned CNT_W = $clog2(TOTAL + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WR     = 2'd1,
    S_RD     = 2'd2,
    S_STREAM = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       div_q, div_d;
  logic             pend_rd_q, pend_rd_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       buf_q [N_REGS];
  logic [7:0]       buf_d [N_REGS];

  logic             bus_req_q, bus_req_d;
  logic             bus_we_q, bus_we_d;
  logic [7:0]       bus_addr_q, bus_addr_d;
  logic [7:0]       bus_wdata_q, bus_wdata_d;
  logic             wr_ack_q, wr_ack_d;
  logic             ini_q, ini_d;
  logic [7:0]       dato_q, dato_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic             acc_tmo;
  logic             acc_end;

  // An access ends on bus_done or on its TIMEOUT-th cycle without one.
  assign acc_tmo = bus_req_q && !bus_done && (tmo_q == TMO_W'(TIMEOUT - 1));
  assign acc_end = bus_req_q && (bus_done || acc_tmo);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      pend_rd_q   <= 1'b0;
      idx_q       <= '0;
      tmo_q       <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < int'(N_REGS); i++) buf_q[i] <= 8'h00;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 8'h00;
      bus_wdata_q <= 8'h00;
      wr_ack_q    <= 1'b0;
      ini_q       <= 1'b0;
      dato_q      <= 8'h00;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      pend_rd_q   <= pend_rd_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      cnt_q       <= cnt_d;
      for (int i = 0; i < int'(N_REGS); i++) buf_q[i] <= buf_d[i];
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      wr_ack_q    <= wr_ack_d;
      ini_q       <= ini_d;
      dato_q      <= dato_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    pend_rd_d = pend_rd_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    buf_d     = buf_q;

    case (state_q)
      S_IDLE: begin
        // wr_req is still high in the cycle wr_ack is seen; ignoring it then avoids a repeat write.
        if (wr_req && !wr_ack_q) begin
          state_d = S_WR;
          tmo_d   = '0;
        end else if (pend_rd_q) begin
          state_d   = S_RD;
          idx_d     = '0;
          tmo_d     = '0;
          pend_rd_d = 1'b0;
          err_d     = 1'b0;
        end
      end
      S_WR: begin
        if (acc_tmo) err_d = 1'b1;
        if (acc_end) state_d = S_IDLE;
        else         tmo_d   = tmo_q + TMO_W'(1);
      end
      S_RD: begin
        if (bus_req_q) begin
          if (acc_end) begin
            buf_d[idx_q] = acc_tmo ? 8'h00 : bus_rdata;
            if (acc_tmo) err_d = 1'b1;
            if (idx_q == IDX_W'(N_REGS - 1)) begin
              state_d = S_STREAM;
              cnt_d   = '0;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end else begin
          tmo_d = '0;
        end
      end
      S_STREAM: begin
        if (cnt_q == CNT_W'(TOTAL - 1)) state_d = S_IDLE;
        else                            cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // Divider runs in every state; a tick arriving as a refresh starts re-arms the pending flag.
    if (frame_tick) begin
      if (div_q == 8'(REFRESH_DIV - 1)) begin
        div_d     = 8'h00;
        pend_rd_d = 1'b1;
      end else begin
        div_d = div_q + 8'h01;
      end
    end
  end

  always_comb begin
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    wr_ack_d    = 1'b0;
    ini_d       = 1'b0;
    dato_d      = 8'h00;
    busy_d      = (state_d != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (state_d == S_WR) begin
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b1;
          bus_addr_d  = wr_addr;
          bus_wdata_d = wr_data;
        end else if (state_d == S_RD) begin
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = BASE_ADDR;
          bus_wdata_d = 8'h00;
        end
      end
      S_WR: begin
        if (acc_end) begin
          wr_ack_d    = 1'b1;
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          bus_addr_d  = 8'h00;
          bus_wdata_d = 8'h00;
        end
      end
      S_RD: begin
        if (bus_req_q) begin
          if (acc_end) begin
            bus_req_d  = 1'b0;
            bus_addr_d = 8'h00;
          end
        end else begin
          // One idle cycle between reads, then the next register address.
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = BASE_ADDR + 8'(idx_q);
          bus_wdata_d = 8'h00;
        end
      end
      default: ;
    endcase

    if (state_d == S_STREAM) begin
      ini_d = 1'b1;
      if (cnt_d >= CNT_W'(LEAD) && cnt_d < CNT_W'(LEAD + N_REGS))
        dato_d = buf_d[IDX_W'(cnt_d - CNT_W'(LEAD))];
    end
  end

  assign wr_ack          = wr_ack_q;
  assign bus_req         = bus_req_q;
  assign bus_we          = bus_we_q;
  assign bus_addr        = bus_addr_q;
  assign bus_wdata       = bus_wdata_q;
  assign inicioSecuencia = ini_q;
  assign datoRTC         = dato_q;
  assign busy            = busy_q;
  assign err             = err_q;

endmodule

// File: tb/tb_rtc_refresh_scheduler.sv
// Directed bench for rtc_refresh_scheduler: bus engine model, stream/access monitors, linear test steps.
module tb_rtc_refresh_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick, wr_req;
  logic [7:0] wr_addr, wr_data;
  logic       wr_ack, bus_req, bus_we, bus_done, ini, busy, err;
  logic [7:0] bus_addr, bus_wdata, bus_rdata, dato;

  logic       tick4, wr_req4;
  logic       wr_ack4, bus_req4, bus_we4, bus_done4, ini4, busy4, err4;
  logic [7:0] bus_addr4, bus_wdata4, dato4;
  logic [7:0] bus_rdata4 = 8'h00;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic       stall = 1'b0;
  int         rcnt;

  logic [7:0]  cur[$];
  logic [7:0]  last[$];
  logic [16:0] acc_log[$];
  int          n_streams = 0;
  int          n_streams4 = 0;
  logic        ini_prev = 1'b0;
  logic        ini4_prev = 1'b0;

  always #5 clk = ~clk;

  rtc_refresh_scheduler dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_done(bus_done), .bus_rdata(bus_rdata),
    .inicioSecuencia(ini), .datoRTC(dato), .busy(busy), .err(err)
  );

  rtc_refresh_scheduler #(.REFRESH_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .frame_tick(tick4),
    .wr_req(wr_req4), .wr_addr(8'h00), .wr_data(8'h00), .wr_ack(wr_ack4),
    .bus_req(bus_req4), .bus_we(bus_we4), .bus_addr(bus_addr4), .bus_wdata(bus_wdata4),
    .bus_done(bus_done4), .bus_rdata(bus_rdata4),
    .inicioSecuencia(ini4), .datoRTC(dato4), .busy(busy4), .err(err4)
  );

  // Bus engine: done 3 cycles after bus_req, rdata = addr - 0x20; stall suppresses the 0x23 read.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rcnt <= 0; bus_done <= 1'b0; bus_rdata <= 8'h00;
    end else begin
      bus_done <= 1'b0;
      if (bus_req && !bus_done) begin
        if (rcnt == 2 && !(stall && !bus_we && bus_addr == 8'h23)) begin
          bus_done  <= 1'b1;
          bus_rdata <= bus_we ? 8'h00 : bus_addr - 8'h20;
          rcnt      <= 0;
        end else begin
          rcnt <= rcnt + 1;
        end
      end else begin
        rcnt <= 0;
      end
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) bus_done4 <= 1'b0;
    else        bus_done4 <= bus_req4 && !bus_done4;
  end

  always @(negedge clk) begin
    if (bus_req && bus_done) acc_log.push_back({bus_we, bus_addr, bus_wdata});
    if (ini) cur.push_back(dato);
    if (ini_prev && !ini) begin
      last = cur;
      cur.delete();
      n_streams++;
    end
    ini_prev = ini;
    if (ini4_prev && !ini4) n_streams4++;
    ini4_prev = ini4;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_streams(input int target, input int budget, input string tag);
    for (int c = 0; c < budget && n_streams < target; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk(tag, n_streams, target);
  endtask

  task automatic tick_pulse();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic wait_ini_high(input string tag);
    int c;
    for (c = 0; c < 400 && !ini; c++) @(negedge clk);
    chk(tag, ini, 1);
  endtask

  // Expected stream byte: 10 leading zeros, 0x01..0x08, 3 trailing zeros; skip_slot forced to 0.
  function automatic logic [7:0] exp_byte(input int i, input int skip_slot);
    if (i >= 10 && i < 18 && i != skip_slot) return 8'(i - 9);
    return 8'h00;
  endfunction

  task automatic chk_stream(input string tag, input int skip_slot);
    chk({tag, "_len"}, last.size(), 21);
    for (int i = 0; i < 21; i++)
      if (i < last.size()) chk($sformatf("%s_b%0d", tag, i), last[i], exp_byte(i, skip_slot));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, base4, lb, c, viol, first_seen;
    reset = 1'b0; frame_tick = 1'b0; wr_req = 1'b0; wr_addr = 8'h00; wr_data = 8'h00;
    tick4 = 1'b0; wr_req4 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ini", ini, 0);
    chk("rst_err", err, 0);
    chk("rst_wr_ack", wr_ack, 0);
    reset = 1'b1;
    @(negedge clk);

    // Plain refresh: eight reads then the framed stream.
    tick_pulse();
    wait_streams(1, 600, "t2_stream");
    chk_stream("t2", -1);
    for (int k = 0; k < 8; k++)
      if (k < acc_log.size()) chk($sformatf("t2_rd%0d", k), acc_log[k], {1'b0, 8'(33 + k), 8'h00});
    chk("t2_err", err, 0);
    chk("t2_busy", busy, 0);
    $display("t2: refresh streamed %0d bytes", last.size());

    // Write and tick in the same cycle: write first, then the refresh.
    lb = acc_log.size();
    base = n_streams;
    wr_req = 1'b1; wr_addr = 8'h22; wr_data = 8'h45; frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    for (c = 0; c < 50 && !wr_ack; c++) @(negedge clk);
    chk("t3_wr_ack", wr_ack, 1);
    wr_req = 1'b0;
    wait_streams(base + 1, 600, "t3_stream");
    if (lb < acc_log.size()) chk("t3_first_wr", acc_log[lb], {1'b1, 8'h22, 8'h45});
    if (lb + 8 < acc_log.size()) chk("t3_last_rd", acc_log[lb + 8], {1'b0, 8'h28, 8'h00});
    chk("t3_log_len", acc_log.size() - lb, 9);
    chk_stream("t3", -1);
    $display("t3: write then refresh, %0d accesses", acc_log.size() - lb);

    // Two ticks during a stream merge into one further refresh.
    base = n_streams;
    tick_pulse();
    wait_ini_high("t4_ini_rise");
    tick_pulse();
    repeat (3) @(negedge clk);
    tick_pulse();
    wait_streams(base + 2, 800, "t4_two_streams");
    repeat (300) @(negedge clk);
    chk("t4_merge", n_streams, base + 2);
    $display("t4: %0d refreshes after merged ticks", n_streams - base);

    // DIV=4 instance: refresh only on the 4th and 8th tick.
    base4 = n_streams4;
    for (int t = 1; t <= 8; t++) begin
      tick4 = 1'b1;
      @(negedge clk);
      tick4 = 1'b0;
      repeat (100) @(negedge clk);
      if (t == 3) chk("t4_div_3ticks", n_streams4, base4);
      if (t == 4) chk("t4_div_4ticks", n_streams4, base4 + 1);
    end
    chk("t4_div_8ticks", n_streams4, base4 + 2);
    $display("t4: div4 instance gave %0d refreshes", n_streams4 - base4);

    // Read of register 2 never completes: timeout, byte forced to 0, err sticky.
    stall = 1'b1;
    base = n_streams;
    tick_pulse();
    wait_streams(base + 1, 1500, "t5_stream");
    chk("t5_err_set", err, 1);
    chk_stream("t5", 12);
    stall = 1'b0;
    repeat (20) @(negedge clk);
    chk("t5_err_sticky", err, 1);
    tick_pulse();
    repeat (3) @(negedge clk);
    chk("t5_err_cleared", err, 0);
    wait_streams(base + 2, 600, "t5_stream2");
    if (last.size() > 12) chk("t5_b12_recovered", last[12], 8'h03);
    $display("t5: timeout refresh and recovery done");

    // Reset mid-read: outputs drop and no stream follows until a new tick.
    base = n_streams;
    tick_pulse();
    for (c = 0; c < 20 && !bus_req; c++) @(negedge clk);
    chk("t1_in_rd", bus_req, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("t1_bus_req", bus_req, 0);
    chk("t1_busy", busy, 0);
    chk("t1_addr", bus_addr, 0);
    chk("t1_ini", ini, 0);
    reset = 1'b1;
    repeat (300) @(negedge clk);
    chk("t1_no_stream", n_streams, base);
    chk("t1_idle", busy, 0);
    tick_pulse();
    wait_streams(base + 1, 600, "t1_stream");
    chk_stream("t1", -1);
    $display("t1: reset mid-read, clean refresh after new tick");

    // wr_req during a stream waits until inicioSecuencia falls.
    base = n_streams;
    lb = acc_log.size();
    tick_pulse();
    wait_ini_high("t6_ini_rise");
    wr_req = 1'b1; wr_addr = 8'h30; wr_data = 8'h99;
    viol = 0; first_seen = 0;
    for (c = 0; c < 200 && !wr_ack; c++) begin
      @(negedge clk);
      if (bus_req && ini) viol++;
      if (bus_req && first_seen == 0) begin
        first_seen = 1;
        chk("t6_stream_done_first", n_streams, base + 1);
      end
    end
    chk("t6_wr_ack", wr_ack, 1);
    wr_req = 1'b0;
    chk("t6_overlap", viol, 0);
    if (acc_log.size() > 0) chk("t6_wr_log", acc_log[acc_log.size() - 1], {1'b1, 8'h30, 8'h99});
    chk("t6_log_len", acc_log.size() - lb, 9);
    $display("t6: write deferred until stream end");

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
